alu: RTL and testbench

- 16-bit registered arithmetic/logic unit for the CPU datapath.
- Takes two operands and a 4-bit operation select, computes the result combinationally, and registers it with zero and sign flags.
- Outputs are valid one clock after the inputs are applied.
- Sits between the register-file read ports and the writeback/branch logic.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_shifter.sv | 27 ++
 rtl/alu.sv | 85 ++++++++
 tb/tb_alu.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and enumerated types for the registered ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: WIDTH, SHAMT_W, the 4-bit opcode enum alu_op_e and the shifter mode enum.
package alu_pkg;

  localparam int WIDTH   = 16;
  localparam int SHAMT_W = 4;

  // ctl encoding; all 16 codes are defined, so there is no illegal opcode.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_SRA   = 4'd8,
    ALU_SLT   = 4'd9,
    ALU_SLTU  = 4'd10,
    ALU_PASSA = 4'd11,
    ALU_PASSB = 4'd12,
    ALU_NOT   = 4'd13,
    ALU_INC   = 4'd14,
    ALU_DEC   = 4'd15
  } alu_op_e;

  // Shifter operation; SH_PASS returns the operand unchanged.
  typedef enum logic [1:0] {
    SH_SLL  = 2'd0,
    SH_SRL  = 2'd1,
    SH_SRA  = 2'd2,
    SH_PASS = 2'd3
  } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter: logical left, logical right, arithmetic right.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: a (operand), shamt (shift amount), mode (shift_mode_e), y (shifted result).
module alu_shifter #(
  parameter int WIDTH   = alu_pkg::WIDTH,
  parameter int SHAMT_W = alu_pkg::SHAMT_W
) (
  input  logic [WIDTH-1:0]        a,
  input  logic [SHAMT_W-1:0]      shamt,
  input  alu_pkg::shift_mode_e    mode,
  output logic [WIDTH-1:0]        y
);
  import alu_pkg::*;

  always_comb begin
    y = a;
    case (mode)
      SH_SLL:  y = a << shamt;
      SH_SRL:  y = a >> shamt;
      // Arithmetic shift needs a signed operand so the MSB is replicated.
      SH_SRA:  y = $unsigned($signed(a) >>> shamt);
      default: y = a;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered 16-bit ALU: 16 arithmetic/logic/shift/compare ops with zero and sign flags.
// Latency: 1 cycle; inputs sampled at a rising clk edge appear on y/z/sign right after it.
// Backpressure: none; a new operation is accepted every cycle.
// Ports: clk, rst (async active-high), a, b, ctl (alu_op_e code), y (result), z (y==0), sign (y MSB).
module alu #(
  parameter int WIDTH   = alu_pkg::WIDTH,
  parameter int SHAMT_W = alu_pkg::SHAMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctl,
  output logic [WIDTH-1:0] y,
  output logic             z,
  output logic             sign
);
  import alu_pkg::*;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  alu_op_e          op;
  shift_mode_e      sh_mode;
  logic [WIDTH-1:0] sh_y;
  logic [WIDTH-1:0] res;

  assign op = alu_op_e'(ctl);

  always_comb begin
    sh_mode = SH_PASS;
    case (op)
      ALU_SLL: sh_mode = SH_SLL;
      ALU_SRL: sh_mode = SH_SRL;
      ALU_SRA: sh_mode = SH_SRA;
      default: sh_mode = SH_PASS;
    endcase
  end

  // Only the low SHAMT_W bits of b form the shift amount; the rest are ignored.
  alu_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .a     (a),
    .shamt (b[SHAMT_W-1:0]),
    .mode  (sh_mode),
    .y     (sh_y)
  );

  always_comb begin
    res = '0;
    case (op)
      ALU_ADD:   res = a + b;
      ALU_SUB:   res = a - b;
      ALU_AND:   res = a & b;
      ALU_OR:    res = a | b;
      ALU_XOR:   res = a ^ b;
      ALU_NOR:   res = ~(a | b);
      ALU_SLL:   res = sh_y;
      ALU_SRL:   res = sh_y;
      ALU_SRA:   res = sh_y;
      ALU_SLT:   res = ($signed(a) < $signed(b)) ? ONE : '0;
      ALU_SLTU:  res = (a < b) ? ONE : '0;
      ALU_PASSA: res = a;
      ALU_PASSB: res = b;
      ALU_NOT:   res = ~a;
      ALU_INC:   res = a + ONE;
      ALU_DEC:   res = a - ONE;
    endcase
  end

  // Flags come from the same next-state value as y so all three stay consistent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y    <= '0;
      z    <= 1'b1;
      sign <= 1'b0;
    end else begin
      y    <= res;
      z    <= (res == '0);
      sign <= res[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: scoreboard queue of expected results, one task per scenario.
// Latency: checks each result one rising edge after its inputs are driven.
// Backpressure: n/a.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  ctl;
  logic [15:0] y;
  logic        z;
  logic        sign;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] exp_q[$];

  alu dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .ctl  (ctl),
    .y    (y),
    .z    (z),
    .sign (sign)
  );

  always #5 clk = ~clk;

  // Independent reference model of the opcode map.
  function automatic logic [15:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic [3:0] mc);
    logic [3:0]  s;
    logic [15:0] r;
    s = mb[3:0];
    r = 16'h0;
    case (mc)
      4'd0:  r = ma + mb;
      4'd1:  r = ma - mb;
      4'd2:  r = ma & mb;
      4'd3:  r = ma | mb;
      4'd4:  r = ma ^ mb;
      4'd5:  r = ~(ma | mb);
      4'd6:  r = ma << s;
      4'd7:  r = ma >> s;
      4'd8:  r = (ma >> s) | (ma[15] ? ~(16'hFFFF >> s) : 16'h0000);
      4'd9:  r = {15'h0, ((ma ^ 16'h8000) < (mb ^ 16'h8000))};
      4'd10: r = {15'h0, (ma < mb)};
      4'd11: r = ma;
      4'd12: r = mb;
      4'd13: r = ~ma;
      4'd14: r = ma + 16'd1;
      default: r = ma - 16'd1;
    endcase
    return r;
  endfunction

  task automatic drive(input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic [3:0] tc, input logic [15:0] ey);
    a   = ta;
    b   = tb_v;
    ctl = tc;
    exp_q.push_back(ey);
  endtask

  task automatic test_reset();
    // Reset state before any edge.
    #3;
    tests_run++;
    if (y !== 16'h0 || z !== 1'b1 || sign !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_initial: y=%h z=%b sign=%b, expected y=0000 z=1 sign=0", y, z, sign);
    end
    // Held across a clock edge while rst is high.
    @(posedge clk); #1;
    tests_run++;
    if (y !== 16'h0 || z !== 1'b1 || sign !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_held: y=%h z=%b sign=%b, expected y=0000 z=1 sign=0", y, z, sign);
    end
    @(negedge clk);
    rst = 1'b0;
    a = 16'd25; b = 16'd25; ctl = 4'd0;
    @(posedge clk); #1;
    tests_run++;
    if (y !== 16'h0032 || z !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_preop: y=%h z=%b, expected y=0032 z=0", y, z);
    end
    // Mid-cycle reset pulse: outputs must clear with no clock edge.
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (y !== 16'h0 || z !== 1'b1 || sign !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: y=%h z=%b sign=%b, expected y=0000 z=1 sign=0", y, z, sign);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (y !== 16'h0032 || z !== 1'b0 || sign !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: y=%h z=%b sign=%b, expected y=0032 z=0 sign=0", y, z, sign);
    end
  endtask

  task automatic test_arith_logic();
    logic [3:0]  ops [6]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    logic [15:0] exps [6] = '{16'h0032, 16'h0000, 16'h0019, 16'h0019, 16'h0000, 16'hFFE6};
    logic [15:0] e;
    for (int i = 0; i < 6; i++) begin
      drive(16'd25, 16'd25, ops[i], exps[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      tests_run++;
      if (y !== e || z !== (e == 16'h0) || sign !== e[15]) begin
        tests_failed++;
        $display("FAIL arith_logic[ctl=%0d]: y=%h z=%b sign=%b, expected y=%h z=%b sign=%b",
                 ops[i], y, z, sign, e, (e == 16'h0), e[15]);
      end
    end
  endtask

  task automatic test_shift_compare();
    logic [3:0]  ops [5]  = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
    logic [15:0] exps [5] = '{16'hEC00, 16'h007F, 16'hFFFF, 16'h0001, 16'h0000};
    logic [15:0] e;
    for (int i = 0; i < 5; i++) begin
      drive(16'hFFF6, 16'd25, ops[i], exps[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      tests_run++;
      if (y !== e || z !== (e == 16'h0) || sign !== e[15]) begin
        tests_failed++;
        $display("FAIL shift_compare[ctl=%0d]: y=%h z=%b sign=%b, expected y=%h z=%b sign=%b",
                 ops[i], y, z, sign, e, (e == 16'h0), e[15]);
      end
    end
  endtask

  task automatic test_wrap_unary();
    logic [15:0] av [9]   = '{16'h7FFF, 16'h0000, 16'hFFFF, 16'h00FF, 16'h0000,
                              16'hABCD, 16'h8001, 16'h1234, 16'hC3A5};
    logic [15:0] bv [9]   = '{16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h1234,
                              16'h0010, 16'hFFF0, 16'h1234, 16'h0000};
    logic [3:0]  cv [9]   = '{4'd14, 4'd15, 4'd0, 4'd13, 4'd12, 4'd6, 4'd8, 4'd9, 4'd11};
    logic [15:0] exps [9] = '{16'h8000, 16'hFFFF, 16'h0000, 16'hFF00, 16'h1234,
                              16'hABCD, 16'h8001, 16'h0000, 16'hC3A5};
    logic [15:0] e;
    for (int i = 0; i < 9; i++) begin
      drive(av[i], bv[i], cv[i], exps[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      tests_run++;
      if (y !== e || z !== (e == 16'h0) || sign !== e[15]) begin
        tests_failed++;
        $display("FAIL wrap_unary[%0d]: y=%h z=%b sign=%b, expected y=%h z=%b sign=%b",
                 i, y, z, sign, e, (e == 16'h0), e[15]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ta;
    logic [15:0] tb_v;
    logic [15:0] e;
    logic [15:0] prev;
    prev = y;
    for (int r = 0; r < 3; r++) begin
      for (int op = 0; op < 16; op++) begin
        ta   = 16'($urandom);
        tb_v = 16'($urandom);
        if (r == 0) begin
          ta   = 16'd25 + 16'(op);
          tb_v = 16'd25;
        end
        drive(ta, tb_v, 4'(op), model(ta, tb_v, 4'(op)));
        // New inputs must not reach y before the next edge.
        #1;
        tests_run++;
        if (y !== prev) begin
          tests_failed++;
          $display("FAIL b2b_hold[r=%0d ctl=%0d]: y=%h, expected y=%h", r, op, y, prev);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        tests_run++;
        if (y !== e || z !== (e == 16'h0) || sign !== e[15]) begin
          tests_failed++;
          $display("FAIL b2b[r=%0d ctl=%0d a=%h b=%h]: y=%h z=%b sign=%b, expected y=%h z=%b sign=%b",
                   r, op, ta, tb_v, y, z, sign, e, (e == 16'h0), e[15]);
        end
        prev = e;
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_queue: %0d results left, expected 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    a   = 16'h0;
    b   = 16'h0;
    ctl = 4'h0;
    test_reset();
    test_arith_logic();
    test_shift_compare();
    test_wrap_unary();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
